// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: CPU write port and uart_tx drain port of the debug byte FIFO.
// The "master" modport is the CPU / uart_tx side. The "slave" modport is the FIFO.
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] wr_byte;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] tx_byte;
    logic                  tx_DataValid;
    logic                  tx_Active;
    logic                  tx_Done;
    logic [DEPTH_LOG2:0]   fifo_count;
    logic                  overflow;

    modport master (
        output wr_byte, wr_valid, tx_Active, tx_Done,
        input  wr_ready, tx_byte, tx_DataValid, fifo_count, overflow
    );

    modport slave (
        input  wr_byte, wr_valid, tx_Active, tx_Done,
        output wr_ready, tx_byte, tx_DataValid, fifo_count, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus drain controller feeding uart_tx.
// Bytes from the CPU debug port are buffered. Each byte goes to uart_tx as a
// one-cycle DV pulse, and the controller then waits for tx_Done. A write to a
// full FIFO is dropped and sets the sticky overflow flag, so the core never stalls.
// Optional build macro UART_TX_FIFO_CRLF_EN: a head byte 8'h0A is sent as
// 8'h0D followed by 8'h0A.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic          CLK12MHZ,
    input  logic          resetn,
    uart_tx_fifo_if.slave bus
);
    localparam int                  DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL  = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY
    } state_e;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] tx_byte_q, tx_byte_d;
    logic                  tx_dv_q, tx_dv_d;
    state_e                state_q, state_d;

    logic                  wr_en;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;

`ifdef UART_TX_FIFO_CRLF_EN
    localparam logic [DATA_WIDTH-1:0] LF = DATA_WIDTH'(8'h0A);
    localparam logic [DATA_WIDTH-1:0] CR = DATA_WIDTH'(8'h0D);
    logic cr_sent_q, cr_sent_d;
`endif

    // wr_ready depends on the pre-edge count, so a write to a full FIFO is
    // rejected even when a pop happens on the same edge.
    assign bus.wr_ready     = (count_q != FULL);
    assign wr_en            = bus.wr_valid && bus.wr_ready;
    assign head             = mem_q[rd_ptr_q];

    assign bus.tx_byte      = tx_byte_q;
    assign bus.tx_DataValid = tx_dv_q;
    assign bus.fifo_count   = count_q;
    assign bus.overflow     = overflow_q;

    // Storage write. The contents need no reset because count gates every read.
    always_ff @(posedge CLK12MHZ) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.wr_byte;
        end
    end

    // Pointer, occupancy and sticky overflow update.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_en && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!wr_en && pop) begin
            count_d = count_q - 1'b1;
        end
        if (bus.wr_valid && !bus.wr_ready) begin
            overflow_d = 1'b1;
        end
    end

    // Drain FSM next state. ISSUE is always a single cycle. A byte leaves the
    // FIFO on the ISSUE->BUSY edge. While BUSY, only tx_Done is examined.
    always_comb begin
        state_d   = state_q;
        tx_byte_d = tx_byte_q;
        tx_dv_d   = 1'b0;
        pop       = 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
        cr_sent_d = cr_sent_q;
`endif
        case (state_q)
            S_IDLE: begin
                // The tx_Active gate keeps the FIFO from pulsing into a frame
                // that uart_tx is still finishing after a reset of this block.
                if (count_q != '0 && !bus.tx_Active) begin
                    state_d   = S_ISSUE;
                    tx_dv_d   = 1'b1;
                    tx_byte_d = head;
`ifdef UART_TX_FIFO_CRLF_EN
                    // First visit to a LF head sends CR and leaves the LF queued.
                    // The second visit clears cr_sent and sends the LF itself.
                    if (head == LF && !cr_sent_q) begin
                        tx_byte_d = CR;
                        cr_sent_d = 1'b1;
                    end else begin
                        cr_sent_d = 1'b0;
                    end
`endif
                end
            end
            S_ISSUE: begin
                state_d = S_BUSY;
`ifdef UART_TX_FIFO_CRLF_EN
                // cr_sent still set here means the byte just issued was the
                // inserted CR, so the stored LF must not be popped.
                pop = !cr_sent_q;
`else
                pop = 1'b1;
`endif
            end
            S_BUSY: begin
                if (bus.tx_Done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register for the pointers, count, flags and registered uart_tx outputs.
    always_ff @(posedge CLK12MHZ or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_byte_q  <= '0;
            tx_dv_q    <= 1'b0;
            state_q    <= S_IDLE;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_byte_q  <= tx_byte_d;
            tx_dv_q    <= tx_dv_d;
            state_q    <= state_d;
        end
    end

`ifdef UART_TX_FIFO_CRLF_EN
    // CR-inserted marker for the current head LF.
    always_ff @(posedge CLK12MHZ or negedge resetn) begin
        if (!resetn) begin
            cr_sent_q <= 1'b0;
        end else begin
            cr_sent_q <= cr_sent_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo.
// A per-cycle vector table covers latency, gating and simultaneous push/pop.
// Hand-written sequences cover fill/overflow, drain under write pressure,
// reset mid-frame, pointer wrap and the optional CR/LF build.
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DEPTH_LOG2(4), .DATA_WIDTH(8)) bus ();

    uart_tx_fifo #(.DEPTH_LOG2(4), .DATA_WIDTH(8)) dut (
        .CLK12MHZ (clk),
        .resetn   (resetn),
        .bus      (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // The tx_Active/tx_Done inputs come either straight from the table or from the uart_tx model.
    logic use_model = 1'b0;
    logic t_active  = 1'b0;
    logic t_done    = 1'b0;
    logic m_active  = 1'b0;
    logic m_done    = 1'b0;
    int   act_cnt   = 0;
    assign bus.tx_Active = use_model ? m_active : t_active;
    assign bus.tx_Done   = use_model ? m_done   : t_done;

    // uart_tx model: busy for 20 cycles after a DV pulse, then a one-cycle tx_Done.
    always @(negedge clk) begin
        m_done = 1'b0;
        if (act_cnt > 0) begin
            act_cnt = act_cnt - 1;
            if (act_cnt == 0) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end
        if (use_model && bus.tx_DataValid) begin
            act_cnt  = 20;
            m_active = 1'b1;
        end
    end

    // Scoreboard: collect issued bytes and check that each DV pulse lasts one cycle.
    logic [7:0] got_q[$];
    logic [4:0] cnt_q[$];
    logic       prev_dv = 1'b0;
    always @(negedge clk) begin
        if (bus.tx_DataValid) begin
            got_q.push_back(bus.tx_byte);
            cnt_q.push_back(bus.fifo_count);
            checks++;
            if (prev_dv) begin
                failures++;
                $display("FAIL dv_pulse_width actual=2+ cycles required=1 cycle");
            end
        end
        prev_dv = bus.tx_DataValid;
    end

    logic [7:0] exp_q[$];

    typedef struct {
        logic       wv;
        logic [7:0] wb;
        logic       act;
        logic       done;
        logic       e_rdy;
        logic       e_dv;
        logic [7:0] e_byte;
        logic [4:0] e_cnt;
        logic       e_ov;
    } vec_t;
    vec_t tbl[19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic wv, input logic [7:0] wb, input logic act, input logic done);
        bus.wr_valid = wv;
        bus.wr_byte  = wb;
        t_active     = act;
        t_done       = done;
    endtask

    task automatic push_exp(input logic [7:0] b);
`ifdef UART_TX_FIFO_CRLF_EN
        if (b == 8'h0A) exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(b);
    endtask

    // Offer n bytes starting at 'first', one per cycle. With honor=0,
    // wr_valid stays high even while the FIFO is full.
    task automatic stream(input logic [7:0] first, input int n, input bit honor, input string nm);
        int sent = 0;
        int budget = n * 40;
        logic acc;
        while (sent < n && budget > 0) begin
            bus.wr_byte  = first + 8'(sent);
            bus.wr_valid = honor ? bus.wr_ready : 1'b1;
            acc = bus.wr_valid && bus.wr_ready;
            @(negedge clk);
            if (acc) begin
                push_exp(first + 8'(sent));
                sent++;
            end
            budget--;
        end
        bus.wr_valid = 1'b0;
        chk({nm, "_sent"}, sent, n);
    endtask

    task automatic wait_pulses(input int n, input string nm);
        int budget = n * 40 + 40;
        while (got_q.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk({nm, "_timeout"}, (got_q.size() >= n), 1);
        repeat (30) @(negedge clk);
    endtask

    task automatic compare_q(input string nm);
        chk({nm, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", nm, i), got_q[i], exp_q[i]);
        end
    endtask

    initial begin
        // wv wb act done | rdy dv byte cnt ov
        tbl[0]  = '{0, 8'h00, 0, 0, 1, 0, 8'h00, 5'd0, 0};
        tbl[1]  = '{0, 8'h00, 0, 1, 1, 0, 8'h00, 5'd0, 0};
        tbl[2]  = '{1, 8'h41, 0, 0, 1, 0, 8'h00, 5'd1, 0};
        tbl[3]  = '{0, 8'h00, 0, 0, 1, 1, 8'h41, 5'd1, 0};
        tbl[4]  = '{0, 8'h00, 0, 0, 1, 0, 8'h41, 5'd0, 0};
        tbl[5]  = '{0, 8'h00, 1, 0, 1, 0, 8'h41, 5'd0, 0};
        tbl[6]  = '{1, 8'h42, 1, 0, 1, 0, 8'h41, 5'd1, 0};
        tbl[7]  = '{0, 8'h00, 0, 1, 1, 0, 8'h41, 5'd1, 0};
        tbl[8]  = '{0, 8'h00, 1, 0, 1, 0, 8'h41, 5'd1, 0};
        tbl[9]  = '{0, 8'h00, 0, 0, 1, 1, 8'h42, 5'd1, 0};
        tbl[10] = '{1, 8'h43, 0, 0, 1, 0, 8'h42, 5'd1, 0};
        tbl[11] = '{0, 8'h00, 0, 1, 1, 0, 8'h42, 5'd1, 0};
        tbl[12] = '{1, 8'h44, 0, 0, 1, 1, 8'h43, 5'd2, 0};
        tbl[13] = '{0, 8'h00, 0, 0, 1, 0, 8'h43, 5'd1, 0};
        tbl[14] = '{0, 8'h00, 0, 1, 1, 0, 8'h43, 5'd1, 0};
        tbl[15] = '{0, 8'h00, 0, 0, 1, 1, 8'h44, 5'd1, 0};
        tbl[16] = '{0, 8'h00, 0, 0, 1, 0, 8'h44, 5'd0, 0};
        tbl[17] = '{0, 8'h00, 0, 1, 1, 0, 8'h44, 5'd0, 0};
        tbl[18] = '{0, 8'h00, 0, 0, 1, 0, 8'h44, 5'd0, 0};

        // Reset state.
        resetn = 1'b0;
        drv(0, 8'h00, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_dv", bus.tx_DataValid, 0);
        chk("rst_byte", bus.tx_byte, 8'h00);
        chk("rst_count", bus.fifo_count, 0);
        chk("rst_ov", bus.overflow, 0);
        chk("rst_ready", bus.wr_ready, 1);
        resetn = 1'b1;
        @(negedge clk);

        // Per-cycle vector table.
        for (int i = 0; i < 19; i++) begin
            drv(tbl[i].wv, tbl[i].wb, tbl[i].act, tbl[i].done);
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), bus.wr_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_dv", i), bus.tx_DataValid, tbl[i].e_dv);
            chk($sformatf("tbl%0d_byte", i), bus.tx_byte, tbl[i].e_byte);
            chk($sformatf("tbl%0d_count", i), bus.fifo_count, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_ov", i), bus.overflow, tbl[i].e_ov);
        end
        drv(0, 8'h00, 0, 0);
        got_q.delete(); cnt_q.delete(); exp_q.delete();

        // Fill 16 bytes while uart_tx is busy, then overflow on the 17th write.
        t_active = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.wr_valid = 1'b1; bus.wr_byte = 8'(i + 1);
            push_exp(8'(i + 1));
            @(negedge clk);
        end
        bus.wr_valid = 1'b0;
        chk("fill_count", bus.fifo_count, 16);
        chk("fill_ready", bus.wr_ready, 0);
        chk("fill_ov", bus.overflow, 0);
        bus.wr_valid = 1'b1; bus.wr_byte = 8'h11;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        chk("ovf_ov", bus.overflow, 1);
        chk("ovf_count", bus.fifo_count, 16);
        use_model = 1'b1;
        wait_pulses(exp_q.size(), "drain");
        compare_q("drain");
        chk("drain_count", bus.fifo_count, 0);
        chk("drain_ov_sticky", bus.overflow, 1);

        // Drain a full FIFO with wr_valid held high every cycle.
        got_q.delete(); cnt_q.delete(); exp_q.delete();
        use_model = 1'b0; t_active = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.wr_valid = 1'b1; bus.wr_byte = 8'h20 + 8'(i);
            push_exp(8'h20 + 8'(i));
            @(negedge clk);
        end
        bus.wr_valid = 1'b0;
        chk("press_full", bus.fifo_count, 16);
        use_model = 1'b1;
        stream(8'h30, 8, 1'b0, "press");
        wait_pulses(exp_q.size(), "press");
        compare_q("press");
        chk("press_count", bus.fifo_count, 0);

        // Reset while BUSY with uart_tx active and 3 bytes queued.
        got_q.delete(); cnt_q.delete(); exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            bus.wr_valid = 1'b1; bus.wr_byte = 8'h50 + 8'(i);
            @(negedge clk);
        end
        bus.wr_valid = 1'b0;
        chk("busy_count", bus.fifo_count, 3);
        chk("busy_active", bus.tx_Active, 1);
        resetn = 1'b0;
        #1;
        chk("midrst_dv", bus.tx_DataValid, 0);
        chk("midrst_byte", bus.tx_byte, 8'h00);
        chk("midrst_count", bus.fifo_count, 0);
        chk("midrst_ov", bus.overflow, 0);
        chk("midrst_ready", bus.wr_ready, 1);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        got_q.delete(); cnt_q.delete();
        repeat (40) @(negedge clk);
        chk("postrst_pulses", got_q.size(), 0);
        chk("postrst_count", bus.fifo_count, 0);

        // Spurious tx_Done in IDLE with an empty FIFO, then 40 bytes to wrap the pointers.
        use_model = 1'b0;
        drv(0, 8'h00, 0, 1);
        @(negedge clk);
        drv(0, 8'h00, 0, 0);
        @(negedge clk);
        chk("spur_dv", bus.tx_DataValid, 0);
        chk("spur_count", bus.fifo_count, 0);
        got_q.delete(); cnt_q.delete(); exp_q.delete();
        use_model = 1'b1;
        stream(8'h60, 40, 1'b1, "wrap");
        wait_pulses(exp_q.size(), "wrap");
        compare_q("wrap");
        chk("wrap_count", bus.fifo_count, 0);
        chk("wrap_ov", bus.overflow, 0);

`ifdef UART_TX_FIFO_CRLF_EN
        // CR insertion ahead of LF.
        got_q.delete(); cnt_q.delete(); exp_q.delete();
        stream(8'h48, 1, 1'b1, "crlf_h");
        stream(8'h0A, 1, 1'b1, "crlf_lf");
        wait_pulses(3, "crlf");
        compare_q("crlf");
        if (cnt_q.size() >= 3) begin
            chk("crlf_cnt_at_cr", cnt_q[1], 1);
            chk("crlf_cnt_at_lf", cnt_q[2], 1);
        end
        chk("crlf_count", bus.fifo_count, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog against a hung run.
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
